// File: rtl/sprite_palette_pipe.sv
// Runtime-loadable sprite palette with render modes.
// Two-stage lookup: palette read, then mode/key apply.
module sprite_palette_pipe #(
    parameter int              IDX_W = 4,
    parameter int              CH_W  = 4,
    parameter logic [CH_W-1:0] KEY_R = 4'hF,
    parameter logic [CH_W-1:0] KEY_G = 4'h0,
    parameter logic [CH_W-1:0] KEY_B = 4'hF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_waddr,
    input  logic [3*CH_W-1:0] pal_wdata,
    input  logic              tint_we,
    input  logic [3*CH_W-1:0] tint_wdata,
    input  logic              pix_valid,
    input  logic [IDX_W-1:0]  pix_index,
    input  logic [1:0]        pix_mode,
    output logic              out_valid,
    output logic [CH_W-1:0]   red,
    output logic [CH_W-1:0]   green,
    output logic [CH_W-1:0]   blue,
    output logic              transparent
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int RGB_W = 3 * CH_W;
    localparam logic [RGB_W-1:0] KEY = {KEY_R, KEY_G, KEY_B};

    localparam logic [1:0] M_NORM = 2'b00;
    localparam logic [1:0] M_DIM  = 2'b01;
    localparam logic [1:0] M_INV  = 2'b10;
    localparam logic [1:0] M_TINT = 2'b11;

    logic [RGB_W-1:0] pal [DEPTH];
    logic [RGB_W-1:0] tint;

    logic             s1_valid;
    logic [RGB_W-1:0] s1_entry;
    logic [1:0]       s1_mode;

    logic             s2_key;
    logic [CH_W-1:0]  s2_r;
    logic [CH_W-1:0]  s2_g;
    logic [CH_W-1:0]  s2_b;

    // One channel through the selected render mode.
    function automatic logic [CH_W-1:0] apply_mode(
        input logic [CH_W-1:0] c,
        input logic [CH_W-1:0] t,
        input logic [1:0]      m
    );
        logic [CH_W-1:0] res;
        res = c;
        unique case (m)
            M_NORM:  res = c;
            M_DIM:   res = c >> 1;
            M_INV:   res = ~c;
            M_TINT:  res = t;
            default: res = c;
        endcase
        return res;
    endfunction

    // Palette storage: reset fills every entry with the key colour.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pal[i] <= KEY;
            end
        end else if (pal_we) begin
            pal[pal_waddr] <= pal_wdata;
        end
    end

    // Tint colour register, independent of palette writes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tint <= '0;
        end else if (tint_we) begin
            tint <= tint_wdata;
        end
    end

    // Stage 1: read sees the pre-write entry on a same-cycle write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_entry <= '0;
            s1_mode  <= M_NORM;
        end else begin
            s1_valid <= pix_valid;
            s1_entry <= pal[pix_index];
            s1_mode  <= pix_mode;
        end
    end

    // Stage 2 combinational: key test on the raw entry, then mode.
    always_comb begin
        s2_key = (s1_entry == KEY);
        s2_r   = apply_mode(s1_entry[3*CH_W-1:2*CH_W],
                            tint[3*CH_W-1:2*CH_W], s1_mode);
        s2_g   = apply_mode(s1_entry[2*CH_W-1:CH_W],
                            tint[2*CH_W-1:CH_W], s1_mode);
        s2_b   = apply_mode(s1_entry[CH_W-1:0],
                            tint[CH_W-1:0], s1_mode);
        if (s2_key) begin
            s2_r = '0;
            s2_g = '0;
            s2_b = '0;
        end
    end

    // Stage 2 output registers: zeroed whenever nothing is valid.
    always_ff @(posedge Clk) begin
        if (Reset || !s1_valid) begin
            out_valid   <= 1'b0;
            transparent <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else begin
            out_valid   <= 1'b1;
            transparent <= s2_key;
            red         <= s2_r;
            green       <= s2_g;
            blue        <= s2_b;
        end
    end

endmodule

// File: tb/tb_sprite_palette_pipe.sv
// Directed bench for sprite_palette_pipe.
// Packs outputs as {valid, transparent, R, G, B}.
module tb_sprite_palette_pipe;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_waddr = '0;
    logic [11:0] pal_wdata = '0;
    logic        tint_we = 1'b0;
    logic [11:0] tint_wdata = '0;
    logic        pix_valid = 1'b0;
    logic [3:0]  pix_index = '0;
    logic [1:0]  pix_mode = '0;
    logic        out_valid;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        transparent;

    int n_checks = 0;
    int n_fail = 0;

    sprite_palette_pipe dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .pal_we     (pal_we),
        .pal_waddr  (pal_waddr),
        .pal_wdata  (pal_wdata),
        .tint_we    (tint_we),
        .tint_wdata (tint_wdata),
        .pix_valid  (pix_valid),
        .pix_index  (pix_index),
        .pix_mode   (pix_mode),
        .out_valid  (out_valid),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .transparent(transparent)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [13:0] exp);
        logic [13:0] obs;
        obs = {out_valid, transparent, red, green, blue};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        pal_we    = 1'b1;
        pal_waddr = a;
        pal_wdata = d;
        tick();
        pal_we    = 1'b0;
    endtask

    task automatic pix(input logic [3:0] i, input logic [1:0] m);
        pix_valid = 1'b1;
        pix_index = i;
        pix_mode  = m;
    endtask

    initial begin
        tick();
        tick();
        chk("reset_idle", 14'h0000);
        Reset = 1'b0;
        tick();
        chk("post_reset_idle", 14'h0000);

        // Index 3 after reset holds the key
        pix(4'd3, 2'b00);
        tick();
        pix_valid = 1'b0;
        tick();
        chk("key_after_reset", {2'b11, 12'h000});
        tick();
        chk("gap_idle", 14'h0000);

        // Normal-mode stream 2,5,2
        wr(4'd2, 12'hFFF);
        wr(4'd5, 12'h555);
        pix(4'd2, 2'b00);
        tick();
        pix(4'd5, 2'b00);
        tick();
        chk("norm_2_a", {2'b10, 12'hFFF});
        pix(4'd2, 2'b00);
        tick();
        chk("norm_5", {2'b10, 12'h555});
        pix_valid = 1'b0;
        tick();
        chk("norm_2_b", {2'b10, 12'hFFF});
        tick();
        chk("stream_end_idle", 14'h0000);

        // Modes dim/invert/tint on FFF, then dim/invert on 555
        tint_we    = 1'b1;
        tint_wdata = 12'hC0C;
        tick();
        tint_we    = 1'b0;
        pix(4'd2, 2'b01);
        tick();
        pix(4'd2, 2'b10);
        tick();
        chk("dim_FFF", {2'b10, 12'h777});
        pix(4'd2, 2'b11);
        tick();
        chk("inv_FFF", {2'b10, 12'h000});
        pix(4'd5, 2'b01);
        tick();
        chk("tint_C0C", {2'b10, 12'hC0C});
        pix(4'd5, 2'b10);
        tick();
        chk("dim_555", {2'b10, 12'h222});
        pix_valid = 1'b0;
        tick();
        chk("inv_555", {2'b10, 12'hAAA});

        // Same-cycle write/read returns the old entry
        wr(4'd4, 12'h333);
        pal_we    = 1'b1;
        pal_waddr = 4'd4;
        pal_wdata = 12'h909;
        pix(4'd4, 2'b00);
        tick();
        pal_we = 1'b0;
        pix(4'd4, 2'b00);
        tick();
        chk("hazard_old", {2'b10, 12'h333});
        pix_valid = 1'b0;
        tick();
        chk("hazard_new", {2'b10, 12'h909});

        // Key entry in tint mode, near-key entry
        wr(4'd1, 12'hF0F);
        wr(4'd6, 12'h101);
        pix(4'd1, 2'b11);
        tick();
        pix(4'd6, 2'b00);
        tick();
        chk("key_tint", {2'b11, 12'h000});
        pix(4'd6, 2'b11);
        tick();
        chk("near_key", {2'b10, 12'h101});
        pix_valid = 1'b0;
        tick();
        chk("near_key_tint", {2'b10, 12'hC0C});

        // Reset mid-stream discards in-flight pixels
        pix(4'd2, 2'b00);
        tick();
        pix(4'd5, 2'b00);
        Reset = 1'b1;
        tick();
        chk("rst_mid_1", 14'h0000);
        pix(4'd2, 2'b00);
        tick();
        chk("rst_mid_2", 14'h0000);
        pix(4'd5, 2'b00);
        tick();
        chk("rst_mid_3", 14'h0000);
        Reset = 1'b0;
        pix_valid = 1'b0;
        tick();
        chk("rst_after_1", 14'h0000);
        tick();
        chk("rst_after_2", 14'h0000);

        // Palette restored to key
        pix(4'd2, 2'b00);
        tick();
        pix_valid = 1'b0;
        tick();
        chk("restored_key", {2'b11, 12'h000});
        tick();
        chk("final_idle", 14'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
